// File: rtl/mc_controller_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control FSM and its decoder.
package mc_controller_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;

    typedef struct packed {
        logic add;
        logic cin;
        logic aluop;
        logic lui;
        logic regc;
        logic wd;
        logic extop;
        logic bsel;
        logic beq;
        logic jr;
        logic jal;
        logic is_store;
        logic needs_mem;
        logic needs_wb;
        logic illegal;
    } dec_t;

endpackage

// File: rtl/mc_decoder.sv
// Combinational instruction decoder: datapath selects plus phase requirements.
module mc_decoder
    import mc_controller_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [5:0] op;
    logic [5:0] funct;

    assign op    = instr[31:26];
    assign funct = instr[5:0];

    always_comb begin
        dec = '0;
        case (op)
            OP_RTYPE: begin
                // The all-zero word is the only legal nop; anything else with op 0 must match a funct.
                if (instr[25:0] != 26'd0) begin
                    case (funct)
                        FN_ADD: begin
                            dec.regc     = 1'b1;
                            dec.add      = 1'b1;
                            dec.needs_wb = 1'b1;
                        end
                        FN_SUB: begin
                            dec.regc     = 1'b1;
                            dec.add      = 1'b1;
                            dec.cin      = 1'b1;
                            dec.needs_wb = 1'b1;
                        end
                        FN_JR:   dec.jr      = 1'b1;
                        default: dec.illegal = 1'b1;
                    endcase
                end
            end
            OP_ORI: begin
                dec.bsel     = 1'b1;
                dec.aluop    = 1'b1;
                dec.needs_wb = 1'b1;
            end
            OP_LUI: begin
                dec.bsel     = 1'b1;
                dec.lui      = 1'b1;
                dec.needs_wb = 1'b1;
            end
            OP_LW: begin
                dec.bsel      = 1'b1;
                dec.extop     = 1'b1;
                dec.add       = 1'b1;
                dec.wd        = 1'b1;
                dec.needs_mem = 1'b1;
                dec.needs_wb  = 1'b1;
            end
            OP_SW: begin
                dec.bsel      = 1'b1;
                dec.extop     = 1'b1;
                dec.add       = 1'b1;
                dec.needs_mem = 1'b1;
                dec.is_store  = 1'b1;
            end
            OP_BEQ: begin
                dec.add = 1'b1;
                dec.cin = 1'b1;
                dec.beq = 1'b1;
            end
            OP_JAL: begin
                dec.jal      = 1'b1;
                dec.needs_wb = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle control FSM: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// gates PC, GRF and DM strobes to the right phase and counts retired instructions.
module mc_controller
    import mc_controller_pkg::*;
#(
    parameter int CNT_W           = 32,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             result,
    input  logic             dm_ready,
    output logic             add,
    output logic             cin,
    output logic             aluop,
    output logic             lui,
    output logic             RegC,
    output logic             WD,
    output logic             EXTop,
    output logic             Bsel,
    output logic             beq,
    output logic             jr,
    output logic             jal,
    output logic             we,
    output logic             sw,
    output logic             pc_en,
    output logic             ir_en,
    output logic             halted,
    output logic [CNT_W-1:0] instr_cnt,
    output state_t           dbg_state
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    dec_t   dec;
    state_t state_q;
    state_t state_d;
    logic   final_ph;

    mc_decoder u_decoder (
        .instr (instr),
        .dec   (dec)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_FETCH;
            instr_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (final_ph) begin
                instr_cnt <= instr_cnt + CNT_ONE;
            end
        end
    end

    // dm_ready handshake: while in MEM the access is pending; a cycle with
    // dm_ready=1 completes it (store strobe fires on that cycle) and MEM is left.
    always_comb begin
        state_d  = state_q;
        final_ph = 1'b0;
        case (state_q)
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: state_d = (dec.illegal && HALT_ON_ILLEGAL) ? ST_HALT : ST_EXEC;
            ST_EXEC: begin
                if (dec.needs_mem) begin
                    state_d = ST_MEM;
                end else if (dec.needs_wb) begin
                    state_d = ST_WB;
                end else begin
                    state_d  = ST_FETCH;
                    final_ph = 1'b1;
                end
            end
            ST_MEM: begin
                if (dm_ready) begin
                    if (dec.needs_wb) begin
                        state_d = ST_WB;
                    end else begin
                        state_d  = ST_FETCH;
                        final_ph = 1'b1;
                    end
                end
            end
            ST_WB: begin
                state_d  = ST_FETCH;
                final_ph = 1'b1;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    assign add   = dec.add;
    assign cin   = dec.cin;
    assign aluop = dec.aluop;
    assign lui   = dec.lui;
    assign RegC  = dec.regc;
    assign WD    = dec.wd;
    assign EXTop = dec.extop;
    assign Bsel  = dec.bsel;

    // Strobes are gated with reset so an access cut short by reset never lands.
    assign pc_en = reset && final_ph;
    assign we    = reset && (state_q == ST_WB);
    assign sw    = reset && (state_q == ST_MEM) && dec.is_store && dm_ready;
    // beq marks a taken branch so the NPC can select the branch target directly.
    assign beq   = pc_en && dec.beq && result;
    assign jr    = pc_en && dec.jr;
    assign jal   = pc_en && dec.jal;

    assign ir_en     = (state_q == ST_FETCH);
    assign halted    = (state_q == ST_HALT);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: a default instance and a narrow-counter,
// illegal-as-nop instance are driven from the same instruction stream.
module tb_mc_controller;
    import mc_controller_pkg::*;

    localparam int K_NOP = 0, K_ADD = 1, K_SUB = 2, K_JR = 3, K_ORI = 4;
    localparam int K_LUI = 5, K_LW = 6, K_SW = 7, K_BEQ = 8, K_JAL = 9;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        result;
    logic        dm_ready;

    logic add, cin, aluop, lui, regc, wd, extop, bsel;
    logic beq, jr, jal, we, sw, pc_en, ir_en, halted;
    logic [31:0] instr_cnt;
    state_t      st;

    logic [7:0] w_sel;
    logic [2:0] w_npc;
    logic       w_we, w_sw, w_pc_en, w_ir_en, w_halted;
    logic [3:0] w_cnt;
    state_t     w_st;

    logic [11:0] exp_q[$];
    logic [11:0] mon_e;
    int          n_checks = 0;
    int          n_err = 0;
    logic [31:0] m_cnt;
    logic [3:0]  m_cnt_w;

    logic [31:0] prog [10] = '{32'h00000000, 32'h00221820, 32'h00221822, 32'h03E00008,
                               32'h34010005, 32'h3C011234, 32'h8C020004, 32'hAC020008,
                               32'h10220003, 32'h0C000010};
    int          kinds [10] = '{K_NOP, K_ADD, K_SUB, K_JR, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_JAL};

    mc_controller dut (
        .clk(clk), .reset(reset), .instr(instr), .result(result), .dm_ready(dm_ready),
        .add(add), .cin(cin), .aluop(aluop), .lui(lui), .RegC(regc), .WD(wd),
        .EXTop(extop), .Bsel(bsel), .beq(beq), .jr(jr), .jal(jal), .we(we), .sw(sw),
        .pc_en(pc_en), .ir_en(ir_en), .halted(halted), .instr_cnt(instr_cnt),
        .dbg_state(st)
    );

    mc_controller #(.CNT_W(4), .HALT_ON_ILLEGAL(1'b0)) dut_w (
        .clk(clk), .reset(reset), .instr(instr), .result(result), .dm_ready(dm_ready),
        .add(w_sel[7]), .cin(w_sel[6]), .aluop(w_sel[5]), .lui(w_sel[4]), .RegC(w_sel[3]),
        .WD(w_sel[2]), .EXTop(w_sel[1]), .Bsel(w_sel[0]), .beq(w_npc[2]), .jr(w_npc[1]),
        .jal(w_npc[0]), .we(w_we), .sw(w_sw), .pc_en(w_pc_en), .ir_en(w_ir_en),
        .halted(w_halted), .instr_cnt(w_cnt), .dbg_state(w_st)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] mk(input state_t s, input logic ir, input logic w,
                                       input logic s_w, input logic pc, input logic h,
                                       input logic b, input logic j, input logic jl,
                                       input logic wpc);
        return {s, ir, w, s_w, pc, h, b, j, jl, wpc};
    endfunction

    // Expected {add,cin,aluop,lui,RegC,WD,EXTop,Bsel} for each instruction kind.
    function automatic logic [7:0] sel_of(input int kind);
        case (kind)
            K_ADD:   return 8'b1000_1000;
            K_SUB:   return 8'b1100_1000;
            K_ORI:   return 8'b0010_0001;
            K_LUI:   return 8'b0001_0001;
            K_LW:    return 8'b1000_0111;
            K_SW:    return 8'b1000_0011;
            K_BEQ:   return 8'b1100_0000;
            default: return 8'b0000_0000;
        endcase
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("cycle", {st, ir_en, we, sw, pc_en, halted, beq, jr, jal, w_pc_en}, mon_e);
        end
    end

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("rst_state", st, ST_FETCH);
        check("rst_strobes", {we, sw, pc_en, beq, jr, jal, halted, ir_en}, 8'b0000_0001);
        check("rst_cnt", instr_cnt, 32'd0);
        check("rst_cnt_w", w_cnt, 32'd0);
        m_cnt   = '0;
        m_cnt_w = '0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic do_instr(input logic [31:0] ins, input int kind, input int waits,
                            input logic res);
        logic mem, wb, fin_e, is_sw;
        int   n;
        mem   = (kind == K_LW) || (kind == K_SW);
        is_sw = (kind == K_SW);
        wb    = kind inside {K_ADD, K_SUB, K_ORI, K_LUI, K_LW, K_JAL};
        fin_e = !mem && !wb;
        exp_q.push_back(mk(ST_FETCH, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(ST_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(ST_EXEC, 0, 0, 0, fin_e, 0, fin_e && kind == K_BEQ && res,
                           fin_e && kind == K_JR, 0, fin_e));
        n = 3;
        if (mem) begin
            for (int i = 0; i < waits; i++) begin
                exp_q.push_back(mk(ST_MEM, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                n++;
            end
            exp_q.push_back(mk(ST_MEM, 0, 0, is_sw, is_sw, 0, 0, 0, 0, is_sw));
            n++;
        end
        if (wb) begin
            exp_q.push_back(mk(ST_WB, 0, 1, 0, 1, 0, 0, 0, kind == K_JAL, 1));
            n++;
        end
        instr  = ins;
        result = res;
        for (int k = 0; k < n; k++) begin
            dm_ready = (k >= 3 + waits);
            if (k == 0) begin
                #1 check("sel", {add, cin, aluop, lui, regc, wd, extop, bsel}, sel_of(kind));
            end
            @(posedge clk);
            #1;
        end
        m_cnt++;
        m_cnt_w++;
        check("cnt", instr_cnt, m_cnt);
        check("cnt_w", w_cnt, m_cnt_w);
    endtask

    initial begin
        int idx;
        reset = 1'b1; instr = '0; result = 1'b0; dm_ready = 1'b0;
        m_cnt = '0; m_cnt_w = '0;
        #2;
        do_reset();

        // Reset landing in EXEC of add: back to FETCH at once, nothing written.
        do_instr(32'h00000000, K_NOP, 0, 0);
        exp_q.push_back(mk(ST_FETCH, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(ST_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        instr = 32'h00221820;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
        end
        check("exec_state", st, ST_EXEC);
        #2 reset = 1'b0;
        #1;
        check("exec_rst_state", st, ST_FETCH);
        check("exec_rst_we", we, 1'b0);
        check("exec_rst_cnt", instr_cnt, 32'd0);
        do_reset();

        do_instr(32'h00221820, K_ADD, 0, 0);
        do_instr(32'h8C020004, K_LW, 3, 0);
        do_instr(32'h10220003, K_BEQ, 0, 1);
        do_instr(32'hAC020008, K_SW, 2, 0);
        do_instr(32'h0C000010, K_JAL, 0, 0);
        do_instr(32'h03E00008, K_JR, 0, 0);

        // Reset landing in WB of lw: the register write strobe drops with it.
        exp_q.push_back(mk(ST_FETCH, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(ST_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(ST_EXEC, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(ST_MEM, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        instr = 32'h8C020004;
        dm_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
        end
        check("wb_we", we, 1'b1);
        reset = 1'b0;
        #1;
        check("wb_rst_we", we, 1'b0);
        check("wb_rst_pc_en", pc_en, 1'b0);
        do_reset();

        for (int i = 0; i < 12; i++) begin
            idx = $urandom_range(0, 9);
            do_instr(prog[idx], kinds[idx], $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // Illegal opcode: default instance halts, narrow instance retires it as a nop.
        do_reset();
        exp_q.push_back(mk(ST_FETCH, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(ST_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 2; k < 6; k++) begin
            exp_q.push_back(mk(ST_HALT, 0, 0, 0, 0, 1, 0, 0, 0, (k == 2) || (k == 5)));
        end
        instr = 32'hFC000000;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
        end
        check("halt_cnt", instr_cnt, m_cnt);
        check("halt_cnt_w", w_cnt, 32'd2);
        do_reset();

        // Sixteen nops: the 4-bit counter wraps back to zero.
        for (int i = 0; i < 16; i++) begin
            do_instr(32'h00000000, K_NOP, 0, 0);
        end
        check("wrap_cnt_w", w_cnt, 32'd0);
        check("wrap_cnt", instr_cnt, 32'd16);

        check("drain", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
